// File: rtl/call_announcer.sv
// Service-desk call announcer: queues up to four {counter, ticket} calls and shows each one
// as BCD digits, blinking for HOLD_CYCLES cycles before moving on to the next queued call.
module call_announcer #(
  parameter int unsigned HOLD_CYCLES  = 50,
  parameter int unsigned BLINK_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       call_valid,
  input  logic [2:0] counter_call,
  input  logic [5:0] number_call,
  output logic [2:0] disp_counter,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       disp_on,
  output logic       busy,
  output logic [2:0] pending,
  output logic       overflow
);

  localparam logic [7:0] HoldLast  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] BlinkLast = 8'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShow} state_e;

  state_e     state_q, state_d;
  logic [8:0] fifo_q [4];
  logic [8:0] fifo_d [4];
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic [8:0] stage_q, stage_d;
  logic [7:0] hold_q, hold_d, blink_q, blink_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic       on_q, on_d;

  logic accept, show_end, pop, push;

  function automatic logic [3:0] bcd_tens(logic [5:0] n);
    if (n >= 6'd60)      return 4'd6;
    else if (n >= 6'd50) return 4'd5;
    else if (n >= 6'd40) return 4'd4;
    else if (n >= 6'd30) return 4'd3;
    else if (n >= 6'd20) return 4'd2;
    else if (n >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] bcd_ones(logic [5:0] n);
    return 4'(n - ({2'b00, bcd_tens(n)} * 6'd10));
  endfunction

  always_comb begin
    accept   = call_valid && (counter_call >= 3'd1) && (counter_call <= 3'd5);
    show_end = (state_q == StShow) && (hold_q == HoldLast);
    pop      = (count_q != 3'd0) && ((state_q == StIdle) || show_end);
    // A pop in the same cycle frees a slot, so a full queue can still take the call.
    push     = accept && ((count_q != 3'd4) || pop);

    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    stage_d = stage_q;
    count_d = count_q;
    ovf_d   = ovf_q | (accept && (count_q == 3'd4) && !pop);

    if (push) begin
      fifo_d[wptr_q] = {counter_call, number_call};
      wptr_d         = wptr_q + 2'd1;
    end
    if (pop) begin
      stage_d = fifo_q[rptr_q];
      rptr_d  = rptr_q + 2'd1;
    end
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    dcnt_d  = dcnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    on_d    = on_q;

    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StLoad;
      end
      StLoad: begin
        dcnt_d  = stage_q[8:6];
        tens_d  = bcd_tens(stage_q[5:0]);
        ones_d  = bcd_ones(stage_q[5:0]);
        hold_d  = 8'd0;
        blink_d = 8'd0;
        on_d    = 1'b1;
        state_d = StShow;
      end
      StShow: begin
        if (show_end) begin
          on_d    = 1'b1;
          state_d = pop ? StLoad : StIdle;
        end else begin
          hold_d = hold_q + 8'd1;
          if (blink_q == BlinkLast) begin
            blink_d = 8'd0;
            on_d    = ~on_q;
          end else begin
            blink_d = blink_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      stage_q <= '0;
      hold_q  <= '0;
      blink_q <= '0;
      dcnt_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fifo_q  <= fifo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      stage_q <= stage_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      dcnt_q  <= dcnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      on_q    <= on_d;
    end
  end

  assign disp_counter = dcnt_q;
  assign disp_tens    = tens_q;
  assign disp_ones    = ones_q;
  assign disp_on      = on_q;
  assign busy         = (state_q != StIdle);
  assign pending      = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_call_announcer.sv
// Self-checking bench for call_announcer: directed scenarios plus random calls, all compared
// against a queue-based behavioural model of the announcer.
module tb_call_announcer;

  localparam int Hold  = 8;
  localparam int Blink = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       call_valid = 1'b0;
  logic [2:0] counter_call = '0;
  logic [5:0] number_call = '0;
  logic [2:0] disp_counter;
  logic [3:0] disp_tens, disp_ones;
  logic       disp_on, busy, overflow;
  logic [2:0] pending;

  int n_checks = 0;
  int n_fails  = 0;

  call_announcer #(.HOLD_CYCLES(Hold), .BLINK_CYCLES(Blink)) dut (
    .clk          (clk),
    .rst          (rst),
    .call_valid   (call_valid),
    .counter_call (counter_call),
    .number_call  (number_call),
    .disp_counter (disp_counter),
    .disp_tens    (disp_tens),
    .disp_ones    (disp_ones),
    .disp_on      (disp_on),
    .busy         (busy),
    .pending      (pending),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 loading, 2 showing; m_k counts cycles into the show.
  logic [8:0] m_q[$];
  int         m_mode, m_k;
  logic [8:0] m_stage;
  logic [2:0] m_cnt;
  logic [3:0] m_tens, m_ones;
  logic       m_on, m_ovf;

  function automatic void model_reset();
    m_q.delete();
    m_mode = 0; m_k = 0; m_stage = '0;
    m_cnt = '0; m_tens = '0; m_ones = '0; m_on = 1'b0; m_ovf = 1'b0;
  endfunction

  function automatic void model_edge(logic v, logic [2:0] c, logic [5:0] n);
    bit endshow, pop, acc;
    endshow = (m_mode == 2) && (m_k == Hold - 1);
    pop     = (m_q.size() > 0) && ((m_mode == 0) || endshow);
    acc     = v && (c >= 1) && (c <= 5);
    case (m_mode)
      0: if (pop) m_mode = 1;
      1: begin
        m_cnt  = m_stage[8:6];
        m_tens = 4'(int'(m_stage[5:0]) / 10);
        m_ones = 4'(int'(m_stage[5:0]) % 10);
        m_k = 0; m_on = 1'b1; m_mode = 2;
      end
      default: begin
        if (endshow) begin
          m_on = 1'b1;
          m_mode = pop ? 1 : 0;
        end else begin
          m_k++;
          m_on = ((m_k / Blink) % 2) == 0;
        end
      end
    endcase
    if (pop) m_stage = m_q.pop_front();
    if (acc) begin
      if (m_q.size() < 4) m_q.push_back({c, n});
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic logic [16:0] dut_vec();
    return {disp_counter, disp_tens, disp_ones, disp_on, busy, pending, overflow};
  endfunction

  function automatic logic [16:0] exp_vec();
    return {m_cnt, m_tens, m_ones, m_on, (m_mode != 0), 3'(m_q.size()), m_ovf};
  endfunction

  task automatic step(input logic v, input logic [2:0] c, input logic [5:0] n);
    call_valid = v; counter_call = c; number_call = n;
    @(posedge clk);
    model_edge(v, c, n);
    #1;
    call_valid = 1'b0; counter_call = '0; number_call = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #4;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 17'd0) begin
      n_fails++; $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    model_reset();
    #8 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'd0, 6'd0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] pat;
    do_reset();
    step(1'b1, 3'd3, 6'd27);
    n_checks++;
    if (busy !== 1'b0 || pending !== 3'd1) begin
      n_fails++; $display("FAIL single_accept: busy %b pending %0d want 0 1", busy, pending);
    end
    step(1'b0, 3'd0, 6'd0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++; $display("FAIL single_load_busy: got %b want 1", busy);
    end
    for (int i = 0; i < Hold; i++) begin
      step(1'b0, 3'd0, 6'd0);
      pat[7-i] = disp_on;
      if (i == 0) begin
        n_checks++;
        if ({disp_counter, disp_tens, disp_ones} !== {3'd3, 4'd2, 4'd7}) begin
          n_fails++;
          $display("FAIL single_display: got %0d/%0d%0d want 3/27",
                   disp_counter, disp_tens, disp_ones);
        end
      end
    end
    n_checks++;
    if (pat !== 8'b1100_1100) begin
      n_fails++; $display("FAIL single_blink: got %b want 11001100", pat);
    end
    step(1'b0, 3'd0, 6'd0);
    n_checks++;
    if (busy !== 1'b0 || disp_on !== 1'b1 || disp_counter !== 3'd3) begin
      n_fails++;
      $display("FAIL single_idle: busy %b on %b cnt %0d want 0 1 3", busy, disp_on, disp_counter);
    end
  endtask

  task automatic test_invalid();
    logic [2:0] codes [4];
    logic       vals [4];
    codes = '{3'd0, 3'd6, 3'd7, 3'd2};
    vals  = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(vals[i], codes[i], 6'(i + 5));
      step(1'b0, 3'd0, 6'd0);
      n_checks++;
      if (pending !== 3'd0 || busy !== 1'b0) begin
        n_fails++;
        $display("FAIL invalid_%0d: pending %0d busy %b want 0 0", codes[i], pending, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs[$];
    logic [10:0] want [4];
    logic [10:0] last;
    want = '{{3'd1, 4'd1, 4'd1}, {3'd2, 4'd2, 4'd2}, {3'd4, 4'd4, 4'd4}, {3'd5, 4'd5, 4'd5}};
    do_reset();
    step(1'b1, 3'd3, 6'd5);
    step(1'b0, 3'd0, 6'd0);
    step(1'b0, 3'd0, 6'd0);
    step(1'b1, 3'd1, 6'd11);
    step(1'b1, 3'd2, 6'd22);
    step(1'b1, 3'd4, 6'd44);
    step(1'b1, 3'd5, 6'd55);
    step(1'b1, 3'd1, 6'd1);
    n_checks++;
    if (pending !== 3'd4 || overflow !== 1'b1) begin
      n_fails++; $display("FAIL b2b_full: pending %0d ovf %b want 4 1", pending, overflow);
    end
    last = {disp_counter, disp_tens, disp_ones};
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 3'd0, 6'd0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL b2b_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if ({disp_counter, disp_tens, disp_ones} !== last) begin
        last = {disp_counter, disp_tens, disp_ones};
        obs.push_back(last);
      end
    end
    n_checks++;
    if (obs.size() != 4) begin
      n_fails++; $display("FAIL b2b_count: got %0d shows want 4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs[i] !== want[i]) begin
          n_fails++; $display("FAIL b2b_order%0d: got %h want %h", i, obs[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    int guard = 0;
    do_reset();
    step(1'b1, 3'd5, 6'd50);
    step(1'b0, 3'd0, 6'd0);
    step(1'b0, 3'd0, 6'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i + 1), 6'(i + 30));
    while (!(m_mode == 2 && m_k == Hold - 1) && guard < 20) begin
      step(1'b0, 3'd0, 6'd0);
      guard++;
    end
    n_checks++;
    if (guard >= 20 || pending !== 3'd4) begin
      n_fails++; $display("FAIL fullpop_setup: pending %0d want 4 (guard %0d)", pending, guard);
    end
    step(1'b1, 3'd2, 6'd33);
    n_checks++;
    if (pending !== 3'd4 || overflow !== 1'b0 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL fullpop_accept: pending %0d ovf %b busy %b want 4 0 1", pending, overflow, busy);
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    step(1'b1, 3'd4, 6'd42);
    step(1'b0, 3'd0, 6'd0);
    step(1'b0, 3'd0, 6'd0);
    step(1'b1, 3'd1, 6'd12);
    step(1'b1, 3'd2, 6'd13);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== 17'd0) begin
      n_fails++; $display("FAIL midreset_async: got %h want 0", dut_vec());
    end
    model_reset();
    #2 rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 3'd0, 6'd0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL midreset_after%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_number_bounds();
    logic [5:0] nums [4];
    logic [7:0] bcd [4];
    nums = '{6'd0, 6'd9, 6'd10, 6'd63};
    bcd  = '{8'h00, 8'h09, 8'h10, 8'h63};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'd2, nums[i]);
      step(1'b0, 3'd0, 6'd0);
      step(1'b0, 3'd0, 6'd0);
      n_checks++;
      if ({disp_tens, disp_ones} !== bcd[i]) begin
        n_fails++;
        $display("FAIL bcd_%0d: got %0d,%0d want %h", nums[i], disp_tens, disp_ones, bcd[i]);
      end
      for (int j = 0; j < Hold; j++) step(1'b0, 3'd0, 6'd0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_invalid();
    test_back_to_back();
    test_full_pop();
    test_reset_mid_show();
    test_number_bounds();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/call_announcer.md
CALL_ANNOUNCER -- requirements
Module: call_announcer

Interface
REQ-001 Parameter HOLD_CYCLES, default 50, number of clock cycles each call is shown blinking (legal range 2..255).
REQ-002 Parameter BLINK_CYCLES, default 5, half-period of the blink in clock cycles (legal range 1..HOLD_CYCLES).
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 call_valid  input  1  one-cycle strobe; counter_call and number_call carry a call event this cycle.
REQ-006 counter_call  input  3  calling counter: 1..5 = A..E; 0, 6 and 7 are invalid.
REQ-007 number_call  input  6  ticket number being called, 0..63.
REQ-008 disp_counter  output  3  counter code currently displayed, same encoding as counter_call.
REQ-009 disp_tens  output  4  BCD tens digit of the displayed number, 0..6.
REQ-010 disp_ones  output  4  BCD ones digit of the displayed number, 0..9.
REQ-011 disp_on  output  1  display enable (blink gate).
REQ-012 busy  output  1  high while an announcement is loading or showing.
REQ-013 pending  output  3  number of calls waiting in the queue, 0..4.
REQ-014 overflow  output  1  sticky flag; a call was dropped because the queue was full.

Function
REQ-015 Accept: call_valid=1 with counter_call in 1..5 is a valid event; any other combination is ignored with no state change.
REQ-016 Queue: 4-entry FIFO of {counter_call, number_call}, in-order, registered on the accepting edge.
REQ-017 Push when full (pending=4) with no pop in the same cycle: event dropped, overflow set to 1 and held until reset.
REQ-018 Push and pop in the same cycle: both take effect; pending unchanged; no overflow even when pending=4.
REQ-019 pending equals the FIFO occupancy after each edge and never exceeds 4 or wraps below 0.
REQ-020 FSM states: IDLE, LOAD, SHOW.
REQ-021 IDLE: when pending>0, pop the head entry and go to LOAD; otherwise remain in IDLE.
REQ-022 LOAD: register the popped entry into disp_counter, disp_tens = number/10, disp_ones = number mod 10; clear the hold and blink timers; set disp_on=1; go to SHOW.
REQ-023 SHOW: lasts exactly HOLD_CYCLES cycles; disp_on toggles every BLINK_CYCLES cycles, starting at 1.
REQ-024 SHOW end: if pending>0, pop and go to LOAD; otherwise go to IDLE with disp_on=1 held steady.
REQ-025 In IDLE the last call remains displayed; after reset with no calls, disp_on=0.
REQ-026 busy=1 in LOAD and SHOW, 0 in IDLE.
REQ-027 Latency: event accepted at edge t into an empty queue while in IDLE: LOAD at edge t+1, display registers valid after edge t+2.
REQ-028 New events arriving during SHOW never alter the current display; they are only queued.

Reset
REQ-029 rst=0 asynchronously forces: state IDLE, FIFO empty, pending=0, overflow=0, disp_counter=0, disp_tens=0, disp_ones=0, disp_on=0, busy=0, timers 0.
REQ-030 Reset asserted mid-SHOW discards the current call and all queued calls; operation resumes from IDLE on the first edge after rst returns high.

Verification (HOLD_CYCLES=8, BLINK_CYCLES=2)
REQ-031 Single call counter 3, number 27, queue empty -> busy rises after edge t+1; after edge t+2 disp_counter=3, tens=2, ones=7; disp_on pattern 1,1,0,0,1,1,0,0; then IDLE with disp_on=1, busy=0.
REQ-032 Invalid codes: counter_call 0, 6, 7 with call_valid=1, and counter_call 2 with call_valid=0 -> pending stays 0, busy stays 0.
REQ-033 Five back-to-back valid calls during a SHOW (queue empty at start) -> pending reaches 4, fifth call dropped, overflow=1; the four queued calls are shown in arrival order, each for 8 cycles.
REQ-034 Queue full and state at SHOW end (pop) with a simultaneous valid call -> call accepted, pending stays 4, overflow stays 0.
REQ-035 rst pulsed low mid-SHOW with 2 calls queued -> all outputs 0 immediately, no call displayed afterward without new input.
REQ-036 Number boundary: calls with numbers 0, 9, 10, 63 -> (tens, ones) = (0,0), (0,9), (1,0), (6,3).
